mm_buf_router: RTL and testbench

- Parametrised buffer-port router between the matrix-multiply core and an array of NUM_BUF on-chip feature buffers.
- Latches one-hot input/output buffer selects per instruction and registers all address, data and write paths.
- Tracks outstanding reads and holds off completion until every in-flight transaction has drained.
- Replaces per-instruction combinational selection with a clocked, checked, N-channel router.

---
 rtl/mm_pkg.sv | 33 +++
 rtl/mm_outst_cnt.sv | 34 +++
 rtl/mm_buf_router.sv | 185 ++++++++++++++++++
 tb/tb_mm_buf_router.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the mm_buf_router slice: FSM encoding, select helpers
// and the outstanding-counter width.
package mm_pkg;

    localparam int MAX_BUF       = 32;
    localparam int DEF_MAX_OUTST = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_MAX_OUTST);

    function automatic logic is_onehot(input logic [MAX_BUF-1:0] v);
        return (v != '0) && ((v & (v - MAX_BUF'(1))) == '0);
    endfunction

    function automatic int onehot_idx(input logic [MAX_BUF-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_BUF; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mm_outst_cnt.sv
// Saturating up/down outstanding-read counter; ovf flags a request that
// arrives while the counter already sits at MAX.
module mm_outst_cnt
    import mm_pkg::*;
#(
    parameter int MAX = DEF_MAX_OUTST,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign ovf = inc && !dec && (cnt == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/mm_buf_router.sv
// Clocked N-channel router between the matmul core and NUM_BUF feature buffers.
// Defining MM_BUF_ROUTER_STATS_EN adds forwarded read/write statistics outputs.
module mm_buf_router
    import mm_pkg::*;
#(
    parameter int NUM_BUF   = 4,
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 11,
    parameter int MAX_OUTST = 8
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      start_valid,
    input  logic [NUM_BUF-1:0]        in_sel,
    input  logic [NUM_BUF-1:0]        out_sel,
    input  logic                      acc_en,
    input  logic                      core_done,
    output logic                      done,
    output logic                      busy,
    output logic                      sel_error,
    output logic                      ovf_error,
    input  logic                      core_in_avalid,
    input  logic [ADDR_W-1:0]         core_in_addr,
    output logic                      core_in_valid,
    output logic [DATA_W-1:0]         core_in_data,
    input  logic                      core_acc_avalid,
    input  logic [ADDR_W-1:0]         core_acc_addr,
    output logic                      core_acc_valid,
    output logic [DATA_W-1:0]         core_acc_data,
    input  logic                      core_wr_valid,
    input  logic [ADDR_W-1:0]         core_wr_addr,
    input  logic [DATA_W-1:0]         core_wr_data,
    output logic [NUM_BUF-1:0]        buf_rd_avalid,
    output logic [NUM_BUF*ADDR_W-1:0] buf_rd_addr,
    input  logic [NUM_BUF-1:0]        buf_rd_valid,
    input  logic [NUM_BUF*DATA_W-1:0] buf_rd_data,
    output logic [NUM_BUF-1:0]        buf_wr_valid,
    output logic [NUM_BUF*ADDR_W-1:0] buf_wr_addr,
    output logic [NUM_BUF*DATA_W-1:0] buf_wr_data
`ifdef MM_BUF_ROUTER_STATS_EN
    ,
    output logic [31:0]               stat_rd_cnt,
    output logic [31:0]               stat_wr_cnt
`endif
);

    localparam int CW    = cnt_width(MAX_OUTST);
    localparam int IDX_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

    state_t             state, state_next;
    logic [NUM_BUF-1:0] in_sel_q, out_sel_q;
    logic               acc_q;
    logic               accept, sel_bad, drained, active;
    logic               in_fwd, acc_fwd, wr_fwd, in_ret, acc_ret;
    logic               in_ovf, acc_ovf;
    logic [CW-1:0]      in_cnt, acc_cnt;
    logic [IDX_W-1:0]   in_idx, out_idx;
    logic [DATA_W-1:0]  rd_data_arr [NUM_BUF];

    for (genvar g = 0; g < NUM_BUF; g++) begin : g_rd_unpack
        assign rd_data_arr[g] = buf_rd_data[g*DATA_W +: DATA_W];
    end

    assign in_idx  = IDX_W'(onehot_idx(MAX_BUF'(in_sel_q)));
    assign out_idx = IDX_W'(onehot_idx(MAX_BUF'(out_sel_q)));

    assign active  = (state != IDLE);
    assign busy    = active;
    assign in_fwd  = active && core_in_avalid;
    assign acc_fwd = active && acc_q && core_acc_avalid;
    assign wr_fwd  = active && core_wr_valid;
    assign in_ret  = active && buf_rd_valid[in_idx];
    assign acc_ret = active && acc_q && buf_rd_valid[out_idx];

    // A request or write in the exit cycle would land after done, so it blocks the exit.
    assign drained = (in_cnt == '0) && (acc_cnt == '0) && !(|buf_wr_valid)
                     && !in_fwd && !acc_fwd && !wr_fwd;

    always_comb begin
        // NOTE: defaults first on every output of this block, so no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        sel_bad    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    if (!is_onehot(MAX_BUF'(in_sel)) || !is_onehot(MAX_BUF'(out_sel))
                        || (acc_en && (in_sel == out_sel))) begin
                        sel_bad = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN:     if (core_done) state_next = DRAIN;
            DRAIN:   if (drained)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge areset) begin
        if (!areset) begin
            state     <= IDLE;
            in_sel_q  <= '0;
            out_sel_q <= '0;
            acc_q     <= 1'b0;
            done      <= 1'b0;
            sel_error <= 1'b0;
            ovf_error <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            done  <= (state == DRAIN) && drained;
            if (accept) begin
                in_sel_q  <= in_sel;
                out_sel_q <= out_sel;
                acc_q     <= acc_en;
            end
            if (sel_bad)     sel_error <= 1'b1;
            else if (accept) sel_error <= 1'b0;
            if (accept)                 ovf_error <= 1'b0;
            else if (in_ovf || acc_ovf) ovf_error <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge areset) begin
        if (!areset) begin
            // NOTE: the wide data registers are reset too, because they drive ports that must read 0 out of reset.
            core_in_valid  <= 1'b0;
            core_in_data   <= '0;
            core_acc_valid <= 1'b0;
            core_acc_data  <= '0;
            buf_rd_avalid  <= '0;
            buf_rd_addr    <= '0;
            buf_wr_valid   <= '0;
            buf_wr_addr    <= '0;
            buf_wr_data    <= '0;
        end else begin
            core_in_valid  <= in_ret;
            core_in_data   <= in_ret ? rd_data_arr[in_idx] : '0;
            core_acc_valid <= acc_ret;
            core_acc_data  <= acc_ret ? rd_data_arr[out_idx] : '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_rd_avalid[i] <= (in_fwd && in_sel_q[i]) || (acc_fwd && out_sel_q[i]);
                buf_rd_addr[i*ADDR_W +: ADDR_W] <= (in_fwd && in_sel_q[i])   ? core_in_addr  :
                                                   (acc_fwd && out_sel_q[i]) ? core_acc_addr : '0;
                buf_wr_valid[i] <= wr_fwd && out_sel_q[i];
                buf_wr_addr[i*ADDR_W +: ADDR_W] <= (wr_fwd && out_sel_q[i]) ? core_wr_addr : '0;
                buf_wr_data[i*DATA_W +: DATA_W] <= (wr_fwd && out_sel_q[i]) ? core_wr_data : '0;
            end
        end
    end

    mm_outst_cnt #(.MAX(MAX_OUTST), .W(CW)) u_in_cnt (
        .clk(ap_clk), .rst_n(areset), .clr(accept),
        .inc(in_fwd), .dec(in_ret), .cnt(in_cnt), .ovf(in_ovf)
    );

    mm_outst_cnt #(.MAX(MAX_OUTST), .W(CW)) u_acc_cnt (
        .clk(ap_clk), .rst_n(areset), .clr(accept),
        .inc(acc_fwd), .dec(acc_ret), .cnt(acc_cnt), .ovf(acc_ovf)
    );

`ifdef MM_BUF_ROUTER_STATS_EN
    logic [32:0] rd_sum, wr_sum;

    assign rd_sum = {1'b0, stat_rd_cnt} + 33'(in_fwd) + 33'(acc_fwd);
    assign wr_sum = {1'b0, stat_wr_cnt} + 33'(wr_fwd);

    always_ff @(posedge ap_clk or negedge areset) begin
        if (!areset) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else if (accept) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else begin
            stat_rd_cnt <= rd_sum[32] ? '1 : rd_sum[31:0];
            stat_wr_cnt <= wr_sum[32] ? '1 : wr_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_mm_buf_router.sv
// Scoreboard bench for mm_buf_router: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares every DUT output event.
module tb_mm_buf_router;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int MO = 8;

    typedef logic [255:0] w_t;

    logic              ap_clk = 1'b0;
    logic              areset = 1'b0;
    logic              start_valid, acc_en, core_done;
    logic [NB-1:0]     in_sel, out_sel;
    logic              done, busy, sel_error, ovf_error;
    logic              core_in_avalid, core_acc_avalid, core_wr_valid;
    logic [AW-1:0]     core_in_addr, core_acc_addr, core_wr_addr;
    logic [DW-1:0]     core_wr_data;
    logic              core_in_valid, core_acc_valid;
    logic [DW-1:0]     core_in_data, core_acc_data;
    logic [NB-1:0]     buf_rd_avalid, buf_rd_valid, buf_wr_valid;
    logic [NB*AW-1:0]  buf_rd_addr, buf_wr_addr;
    logic [NB*DW-1:0]  buf_rd_data, buf_wr_data;
`ifdef MM_BUF_ROUTER_STATS_EN
    logic [31:0]       stat_rd_cnt, stat_wr_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [NB+NB*AW-1:0]       rd_q [$];
    logic [NB+NB*AW+NB*DW-1:0] wr_q [$];
    logic [DW-1:0]             in_q [$];
    logic [DW-1:0]             acc_q [$];
    int                        done_q [$];

    mm_buf_router #(.NUM_BUF(NB), .DATA_W(DW), .ADDR_W(AW), .MAX_OUTST(MO)) dut (
        .ap_clk(ap_clk), .areset(areset), .start_valid(start_valid),
        .in_sel(in_sel), .out_sel(out_sel), .acc_en(acc_en), .core_done(core_done),
        .done(done), .busy(busy), .sel_error(sel_error), .ovf_error(ovf_error),
        .core_in_avalid(core_in_avalid), .core_in_addr(core_in_addr),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_acc_avalid(core_acc_avalid), .core_acc_addr(core_acc_addr),
        .core_acc_valid(core_acc_valid), .core_acc_data(core_acc_data),
        .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .buf_rd_avalid(buf_rd_avalid), .buf_rd_addr(buf_rd_addr),
        .buf_rd_valid(buf_rd_valid), .buf_rd_data(buf_rd_data),
        .buf_wr_valid(buf_wr_valid), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
`ifdef MM_BUF_ROUTER_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ap_clk) begin
        if (areset) begin
            if (buf_rd_avalid != '0) begin
                if (rd_q.size() == 0) check("rd_req_unexpected", w_t'({buf_rd_avalid, buf_rd_addr}), '0);
                else check("rd_req", w_t'({buf_rd_avalid, buf_rd_addr}), w_t'(rd_q.pop_front()));
            end
            if (buf_wr_valid != '0) begin
                if (wr_q.size() == 0) check("wr_unexpected", w_t'({buf_wr_valid, buf_wr_addr, buf_wr_data}), '0);
                else check("wr", w_t'({buf_wr_valid, buf_wr_addr, buf_wr_data}), w_t'(wr_q.pop_front()));
            end
            if (core_in_valid) begin
                if (in_q.size() == 0) check("in_data_unexpected", w_t'(core_in_valid), '0);
                else check("in_data", w_t'(core_in_data), w_t'(in_q.pop_front()));
            end
            if (core_acc_valid) begin
                if (acc_q.size() == 0) check("acc_data_unexpected", w_t'(core_acc_valid), '0);
                else check("acc_data", w_t'(core_acc_data), w_t'(acc_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", w_t'(done), '0);
                else check("done_cycle", w_t'(cyc), w_t'(done_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(negedge ap_clk);
    endtask

    task automatic start(input logic [NB-1:0] i_s, input logic [NB-1:0] o_s, input logic acc);
        start_valid = 1'b1; in_sel = i_s; out_sel = o_s; acc_en = acc;
        step();
        start_valid = 1'b0; in_sel = '0; out_sel = '0; acc_en = 1'b0;
    endtask

    // Targets are the hand-derived buffer masks each request must appear on.
    task automatic issue(input logic iv, input logic [AW-1:0] ia, input logic [NB-1:0] i_tgt,
                         input logic av, input logic [AW-1:0] aa, input logic [NB-1:0] a_tgt,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] w_tgt, input logic cd);
        logic [NB*AW-1:0] ra, wav;
        logic [NB*DW-1:0] wdv;
        ra = '0; wav = '0; wdv = '0;
        for (int i = 0; i < NB; i++) begin
            if (i_tgt[i]) ra[i*AW +: AW] = ia;
            if (a_tgt[i]) ra[i*AW +: AW] = aa;
            if (w_tgt[i]) begin
                wav[i*AW +: AW] = wa;
                wdv[i*DW +: DW] = wd;
            end
        end
        if ((i_tgt | a_tgt) != '0) rd_q.push_back({i_tgt | a_tgt, ra});
        if (w_tgt != '0) wr_q.push_back({w_tgt, wav, wdv});
        core_in_avalid = iv; core_in_addr = ia;
        core_acc_avalid = av; core_acc_addr = aa;
        core_wr_valid = wv; core_wr_addr = wa; core_wr_data = wd;
        core_done = cd;
        step();
        core_in_avalid = 1'b0; core_in_addr = '0;
        core_acc_avalid = 1'b0; core_acc_addr = '0;
        core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
        core_done = 1'b0;
    endtask

    task automatic idle_done();
        issue(0, '0, '0, 0, '0, '0, 0, '0, '0, '0, 1);
    endtask

    // Buffer i returns base|i; ein/eacc are the hand-computed values the core must see.
    task automatic ret(input logic [NB-1:0] mask, input logic [DW-1:0] base,
                       input logic ei, input logic [DW-1:0] ein,
                       input logic ea, input logic [DW-1:0] eacc);
        buf_rd_valid = mask;
        for (int i = 0; i < NB; i++)
            buf_rd_data[i*DW +: DW] = mask[i] ? (base | DW'(i)) : '0;
        if (ei) in_q.push_back(ein);
        if (ea) acc_q.push_back(eacc);
        step();
        buf_rd_valid = '0;
        buf_rd_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check(name, w_t'(busy), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        start_valid = 0; in_sel = '0; out_sel = '0; acc_en = 0; core_done = 0;
        core_in_avalid = 0; core_in_addr = '0; core_acc_avalid = 0; core_acc_addr = '0;
        core_wr_valid = 0; core_wr_addr = '0; core_wr_data = '0;
        buf_rd_valid = '0; buf_rd_data = '0;

        repeat (3) step();
        check("reset_flags", w_t'({done, busy, sel_error, ovf_error, core_in_valid, core_acc_valid,
                                   buf_rd_avalid, buf_wr_valid}), '0);
        check("reset_buses", w_t'({buf_rd_addr, buf_wr_addr, buf_wr_data, core_in_data}), '0);
        areset = 1'b1;
        step();

        // basic input read, ignored strobe, dropped acc request, write
        start(4'b0100, 4'b1000, 1'b0);
        check("basic_busy", w_t'(busy), w_t'(1));
        issue(1, 11'h005, 4'b0100, 0, '0, '0, 0, '0, '0, '0, 0);
        ret(4'b0100, 32'hAB00_0000, 1, 32'hAB00_0002, 0, '0);
        ret(4'b0001, 32'hCD00_0000, 0, '0, 0, '0);
        issue(0, '0, '0, 1, 11'h033, 4'b0000, 0, '0, '0, '0, 0);
        issue(0, '0, '0, 0, '0, '0, 1, 11'h007, 32'h1234_5678, 4'b1000, 0);
        done_q.push_back(cyc + 2);
        idle_done();
        wait_idle("basic_idle");
        check("basic_sel_error", w_t'(sel_error), '0);

        // two set bits in in_sel
        start(4'b0110, 4'b1000, 1'b0);
        check("multi_sel_error", w_t'(sel_error), w_t'(1));
        check("multi_sel_busy", w_t'(busy), '0);
        repeat (3) step();

        // accumulate: acc reads go to the out_sel buffer
        start(4'b0001, 4'b0100, 1'b1);
        check("acc_sel_error_clear", w_t'(sel_error), '0);
        issue(0, '0, '0, 1, 11'h010, 4'b0100, 0, '0, '0, '0, 0);
        issue(1, 11'h020, 4'b0001, 1, 11'h011, 4'b0100, 0, '0, '0, '0, 0);
        ret(4'b0101, 32'h5500_0000, 1, 32'h5500_0000, 1, 32'h5500_0002);
        ret(4'b0100, 32'h6600_0000, 0, '0, 1, 32'h6600_0002);
        issue(0, '0, '0, 0, '0, '0, 1, 11'h010, 32'hDEAD_BEEF, 4'b0100, 0);
        done_q.push_back(cyc + 2);
        idle_done();
        wait_idle("acc_idle");

        // in_sel == out_sel with acc_en
        start(4'b0001, 4'b0001, 1'b1);
        check("same_sel_error", w_t'(sel_error), w_t'(1));
        check("same_sel_busy", w_t'(busy), '0);
        repeat (3) step();

        // drain wait: 3 outstanding, returns 2, 5, 9 cycles after core_done
        start(4'b0010, 4'b1000, 1'b0);
        issue(1, 11'h001, 4'b0010, 0, '0, '0, 0, '0, '0, '0, 0);
        issue(1, 11'h002, 4'b0010, 0, '0, '0, 0, '0, '0, '0, 0);
        c0 = cyc;
        issue(1, 11'h003, 4'b0010, 0, '0, '0, 0, '0, '0, '0, 1);
        while (cyc < c0 + 2) step();
        ret(4'b0010, 32'h1000_0000, 1, 32'h1000_0001, 0, '0);
        while (cyc < c0 + 5) step();
        ret(4'b0010, 32'h2000_0000, 1, 32'h2000_0001, 0, '0);
        while (cyc < c0 + 9) step();
        check("drain_busy_hold", w_t'(busy), w_t'(1));
        done_q.push_back(cyc + 2);
        ret(4'b0010, 32'h3000_0000, 1, 32'h3000_0001, 0, '0);
        wait_idle("drain_idle");

        // overflow: 9 reads, no returns
        start(4'b0001, 4'b0010, 1'b0);
        for (int i = 0; i < MO; i++)
            issue(1, AW'(i), 4'b0001, 0, '0, '0, 0, '0, '0, '0, 0);
        check("ovf_at_max", w_t'(ovf_error), '0);
        issue(1, 11'h008, 4'b0001, 0, '0, '0, 0, '0, '0, '0, 0);
        check("ovf_set", w_t'(ovf_error), w_t'(1));
        check("ovf_cnt_sat", w_t'(dut.u_in_cnt.cnt), w_t'(MO));
        for (int i = 0; i < MO; i++)
            ret(4'b0001, 32'h7700_0000, 1, 32'h7700_0000, 0, '0);
        check("ovf_sticky", w_t'(ovf_error), w_t'(1));
        done_q.push_back(cyc + 2);
        idle_done();
        wait_idle("ovf_idle");

        // reset during DRAIN, then a normal run
        start(4'b0100, 4'b0001, 1'b0);
        check("restart_ovf_clear", w_t'(ovf_error), '0);
        issue(1, 11'h044, 4'b0100, 0, '0, '0, 0, '0, '0, '0, 0);
        issue(1, 11'h045, 4'b0100, 0, '0, '0, 0, '0, '0, '0, 1);
        step();
        check("mid_drain_busy", w_t'(busy), w_t'(1));
        #2 areset = 1'b0;
        #1;
        check("abort_flags", w_t'({done, busy, sel_error, ovf_error, core_in_valid, core_acc_valid,
                                   buf_rd_avalid, buf_wr_valid}), '0);
        check("abort_buses", w_t'({buf_rd_addr, buf_wr_addr, buf_wr_data, core_in_data}), '0);
        repeat (2) step();
        areset = 1'b1;
        step();
        start(4'b0010, 4'b0100, 1'b1);
        check("post_reset_busy", w_t'(busy), w_t'(1));
        issue(1, 11'h0AA, 4'b0010, 1, 11'h0BB, 4'b0100, 1, 11'h0CC, 32'hCAFE_F00D, 4'b0100, 0);
        ret(4'b0110, 32'h9900_0000, 1, 32'h9900_0001, 1, 32'h9900_0002);
        done_q.push_back(cyc + 2);
        idle_done();
        wait_idle("post_reset_idle");

        repeat (3) step();
        check("queues_empty", w_t'(rd_q.size() + wr_q.size() + in_q.size() + acc_q.size() + done_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
